// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the pipeline stage registers: NOP opcodes, bundle
// field layouts for ID/EX, EX/MEM and MEM/WB, per-stage bubbles, state codes.
package pipe_skid_stage_pkg;

    localparam logic [3:0] ALU_NOP_OP = 4'h0;
    localparam logic [1:0] MEM_NOP_OP = 2'b00;
    localparam logic       ZERO       = 1'b0;

    // ID/EX: {op_a, op_b, alu_op, mem_op, wb_en, wb_reg}
    localparam int IDEX_OPA_W    = 16;
    localparam int IDEX_OPB_W    = 16;
    localparam int IDEX_ALU_W    = 4;
    localparam int IDEX_MEM_W    = 2;
    localparam int IDEX_WBEN_W   = 1;
    localparam int IDEX_WBREG_W  = 5;
    localparam int IDEX_WBREG_LO = 0;
    localparam int IDEX_WBEN_LO  = IDEX_WBREG_LO + IDEX_WBREG_W;
    localparam int IDEX_MEM_LO   = IDEX_WBEN_LO + IDEX_WBEN_W;
    localparam int IDEX_ALU_LO   = IDEX_MEM_LO + IDEX_MEM_W;
    localparam int IDEX_OPB_LO   = IDEX_ALU_LO + IDEX_ALU_W;
    localparam int IDEX_OPA_LO   = IDEX_OPB_LO + IDEX_OPB_W;
    localparam int IDEX_W        = IDEX_OPA_LO + IDEX_OPA_W;

    // EX/MEM: {result, store_data, mem_op, wb_en, wb_reg}
    localparam int EXMEM_RES_W    = 16;
    localparam int EXMEM_STD_W    = 16;
    localparam int EXMEM_MEM_W    = 2;
    localparam int EXMEM_WBEN_W   = 1;
    localparam int EXMEM_WBREG_W  = 5;
    localparam int EXMEM_WBREG_LO = 0;
    localparam int EXMEM_WBEN_LO  = EXMEM_WBREG_LO + EXMEM_WBREG_W;
    localparam int EXMEM_MEM_LO   = EXMEM_WBEN_LO + EXMEM_WBEN_W;
    localparam int EXMEM_STD_LO   = EXMEM_MEM_LO + EXMEM_MEM_W;
    localparam int EXMEM_RES_LO   = EXMEM_STD_LO + EXMEM_STD_W;
    localparam int EXMEM_W        = EXMEM_RES_LO + EXMEM_RES_W;

    // MEM/WB: {wb_data, wb_en, wb_reg}
    localparam int MEMWB_DATA_W   = 16;
    localparam int MEMWB_WBEN_W   = 1;
    localparam int MEMWB_WBREG_W  = 5;
    localparam int MEMWB_WBREG_LO = 0;
    localparam int MEMWB_WBEN_LO  = MEMWB_WBREG_LO + MEMWB_WBREG_W;
    localparam int MEMWB_DATA_LO  = MEMWB_WBEN_LO + MEMWB_WBEN_W;
    localparam int MEMWB_W        = MEMWB_DATA_LO + MEMWB_DATA_W;

    // Bubbles: no ALU work, no memory access, register write disabled.
    localparam logic [IDEX_W-1:0]  IDEX_NOP  = {16'h0, 16'h0, ALU_NOP_OP, MEM_NOP_OP, ZERO, 5'h0};
    localparam logic [EXMEM_W-1:0] EXMEM_NOP = {16'h0, 16'h0, MEM_NOP_OP, ZERO, 5'h0};
    localparam logic [MEMWB_W-1:0] MEMWB_NOP = {16'h0, ZERO, 5'h0};

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready/data handshake bundle between pipeline stages.
interface pipe_skid_stage_if #(
    parameter int DATA_W = 44
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_stage.sv
// Flow-controlled stage register with a 2-entry skid buffer; in_ready comes
// from registered state only, so back-pressure never forms a combinational path.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int                DATA_W    = IDEX_W,
    parameter logic [DATA_W-1:0] NOP_VALUE = IDEX_NOP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    pipe_skid_stage_if.slave    up_if,
    pipe_skid_stage_if.master   dn_if,
    output logic [1:0]          occupancy_o
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q;
    logic              in_fire, out_fire, out_valid;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = up_if.valid & in_ready_q;
    assign out_fire  = out_valid & dn_if.ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            // Anything accepted this cycle is dropped; an out_fire has already
            // been sampled downstream, so emptying everything is correct.
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = up_if.data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = up_if.data;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_d  = up_if.data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                        main_d  = NOP_VALUE;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= NOP_VALUE;
            skid_q     <= NOP_VALUE;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    assign up_if.ready = in_ready_q;
    assign dn_if.valid = out_valid;
    assign dn_if.data  = main_q;
    assign occupancy_o = state_q;

endmodule
